// File: rtl/param_updown_counter_if.sv
// Bus interface for param_updown_counter: control strobes, load data, and
// the count/status outputs. The compare port pair exists only when
// PARAM_COUNTER_CMP_EN is defined.
interface param_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             up_dn;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             evt;
    logic             ovf;
    logic             unf;
`ifdef PARAM_COUNTER_CMP_EN
    logic [WIDTH-1:0] cmp_val;
    logic             cmp_hit;
`endif

    modport master (
        output en, load, load_data, up_dn, clr_flags,
`ifdef PARAM_COUNTER_CMP_EN
        output cmp_val,
        input  cmp_hit,
`endif
        input  count, tc, evt, ovf, unf
    );

    modport slave (
        input  en, load, load_data, up_dn, clr_flags,
`ifdef PARAM_COUNTER_CMP_EN
        input  cmp_val,
        output cmp_hit,
`endif
        output count, tc, evt, ovf, unf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Parameterized up/down counter with load, wrap or saturate at the
// boundaries, a one-cycle boundary event pulse and sticky over/underflow
// flags. Optional feature: define PARAM_COUNTER_CMP_EN to add a registered
// compare-hit output against cmp_val.
module param_updown_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    param_updown_counter_if.slave         bus
);
    // One extra bit so MAX_VAL = 2**WIDTH-1 can be compared and stepped
    // without aliasing back into the count range.
    localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, cnt_next;
    logic             evt_q, evt_next;
    logic             ovf_q, unf_q;
    logic             ovf_set, unf_set;
    logic [WIDTH:0]   cnt_ext, inc_ext, dec_ext, load_ext;
    logic             at_max, at_zero;

    assign cnt_ext  = {1'b0, count_q};
    assign inc_ext  = cnt_ext + ONE_EXT;
    assign dec_ext  = cnt_ext - ONE_EXT;
    assign load_ext = {1'b0, bus.load_data};
    assign at_max   = (cnt_ext == MAX_EXT);
    assign at_zero  = (cnt_ext == '0);

    // Next-state selection: load beats an enabled step, otherwise hold.
    always_comb begin
        cnt_next = count_q;
        evt_next = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (bus.load) begin
            cnt_next = (load_ext > MAX_EXT) ? MAX_VAL : bus.load_data;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_max) begin
                    evt_next = 1'b1;
                    ovf_set  = 1'b1;
                    if (!SATURATE) cnt_next = '0;
                end else begin
                    cnt_next = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    evt_next = 1'b1;
                    unf_set  = 1'b1;
                    if (!SATURATE) cnt_next = MAX_VAL;
                end else begin
                    cnt_next = dec_ext[WIDTH-1:0];
                end
            end
        end
    end

    // State register; a flag being set in a cycle wins over clr_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            evt_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= cnt_next;
            evt_q   <= evt_next;
            ovf_q   <= ovf_set | (ovf_q & ~bus.clr_flags);
            unf_q   <= unf_set | (unf_q & ~bus.clr_flags);
        end
    end

    assign bus.count = count_q;
    assign bus.evt   = evt_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
    assign bus.tc    = bus.up_dn ? at_max : at_zero;

`ifdef PARAM_COUNTER_CMP_EN
    logic cmp_hit_q;

    // Flags the cycle after the registered count shows cmp_val.
    always_ff @(posedge clk) begin
        if (reset) cmp_hit_q <= 1'b0;
        else       cmp_hit_q <= (count_q == bus.cmp_val);
    end

    assign bus.cmp_hit = cmp_hit_q;
`endif
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: a wrap-mode counter (WIDTH=4, MAX_VAL=9) and a
// saturate-mode counter (WIDTH=4, MAX_VAL=15) with hand-computed results.
module tb_param_updown_counter;
    logic clk = 1'b0;
    logic reset;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(4)) a ();
    param_updown_counter_if #(.WIDTH(4)) b ();

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(a)
    );
    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int c, input bit e, input bit o, input bit u);
        chk({tag, ".count"}, 32'(a.count), 32'(c));
        chk({tag, ".evt"},   32'(a.evt),   32'(e));
        chk({tag, ".ovf"},   32'(a.ovf),   32'(o));
        chk({tag, ".unf"},   32'(a.unf),   32'(u));
    endtask

    task automatic chk_b(input string tag, input int c, input bit e, input bit o, input bit u);
        chk({tag, ".count"}, 32'(b.count), 32'(c));
        chk({tag, ".evt"},   32'(b.evt),   32'(e));
        chk({tag, ".ovf"},   32'(b.ovf),   32'(o));
        chk({tag, ".unf"},   32'(b.unf),   32'(u));
    endtask

    initial begin
        reset = 1'b1;
        a.en = 0; a.load = 0; a.load_data = '0; a.up_dn = 1; a.clr_flags = 0;
        b.en = 0; b.load = 0; b.load_data = '0; b.up_dn = 1; b.clr_flags = 0;
`ifdef PARAM_COUNTER_CMP_EN
        a.cmp_val = 4'd5;
        b.cmp_val = 4'd0;
`endif
        // Reset with load and en active must still clear everything.
        a.en = 1; a.load = 1; a.load_data = 4'd7;
        tick();
        chk_a("rst", 0, 0, 0, 0);
        chk_b("rst_b", 0, 0, 0, 0);
        chk("rst.tc_up", 32'(a.tc), 32'd0);
        a.up_dn = 0; #1;
        chk("rst.tc_dn", 32'(a.tc), 32'd1);
        a.up_dn = 1; a.load = 0; a.en = 0;
        reset = 1'b0;

        // Wrap count-up: 1..9,0,1,2; evt right after 9->0.
        a.en = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("up%0d", i), 32'(a.count), 32'(i % 10));
            chk($sformatf("up%0d.evt", i), 32'(a.evt), 32'(i == 10));
            chk($sformatf("up%0d.ovf", i), 32'(a.ovf), 32'(i >= 10));
            if (i == 9) chk("up9.tc", 32'(a.tc), 32'd1);
        end
        chk("up.unf", 32'(a.unf), 32'd0);

        // Wrap count-down from 0 gives MAX_VAL and sets unf.
        a.en = 0; a.load = 1; a.load_data = 4'd0;
        tick();
        chk_a("ld0", 0, 0, 1, 0);
        a.load = 0; a.en = 1; a.up_dn = 0;
        tick();
        chk_a("dn_wrap", 9, 1, 1, 1);
        a.en = 0;
        tick();
        chk_a("hold", 9, 0, 1, 1);
        a.clr_flags = 1;
        tick();
        chk_a("clr", 9, 0, 0, 0);
        a.clr_flags = 0;

        // Normal down-step.
        a.en = 1;
        tick();
        chk_a("dn", 8, 0, 0, 0);

        // Flag set in the same cycle as clr_flags wins.
        a.en = 0; a.load = 1; a.load_data = 4'd0;
        tick();
        a.load = 0; a.en = 1; a.up_dn = 0; a.clr_flags = 1;
        tick();
        chk_a("set_vs_clr", 9, 1, 0, 1);
        a.clr_flags = 0; a.en = 0;

        // Load clamps above MAX_VAL, overrides en, and never pulses evt.
        a.up_dn = 1; a.en = 1; a.load = 1; a.load_data = 4'd13;
        tick();
        chk_a("ld13", 9, 0, 0, 1);
        chk("ld13.tc", 32'(a.tc), 32'd1);
        a.load_data = 4'd4;
        tick();
        chk_a("ld4", 4, 0, 0, 1);
        a.load = 0;

        // Reset mid-count with load asserted, then resume from 0.
        a.load = 1; a.load_data = 4'd6;
        tick();
        a.load = 0; a.clr_flags = 0;
        chk("ld6", 32'(a.count), 32'd6);
        reset = 1; a.load = 1; a.load_data = 4'd3; a.en = 1;
        tick();
        chk_a("rst_mid", 0, 0, 0, 0);
        reset = 0; a.load = 0;
        tick();
        chk_a("resume", 1, 0, 0, 0);
        a.en = 0;

        // Saturate mode: hold at 15 with evt on every attempt.
        b.load = 1; b.load_data = 4'd14;
        tick();
        b.load = 0; b.en = 1; b.up_dn = 1;
        tick();
        chk_b("sat_14_15", 15, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_b($sformatf("sat_up%0d", i), 15, 1, 1, 0);
        end
        b.up_dn = 0;
        tick();
        chk_b("sat_15_14", 14, 0, 1, 0);
        b.en = 0; b.load = 1; b.load_data = 4'd0;
        tick();
        b.load = 0; b.en = 1;
        tick();
        chk_b("sat_dn0", 0, 1, 1, 1);
        b.en = 0;
        tick();
        chk_b("sat_idle", 0, 0, 1, 1);

`ifdef PARAM_COUNTER_CMP_EN
        // Compare hit lands the cycle after count reaches cmp_val.
        reset = 1;
        tick();
        chk("cmp.rst", 32'(a.cmp_hit), 32'd0);
        reset = 0; a.en = 1; a.up_dn = 1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("cmp%0d", i), 32'(a.cmp_hit), 32'(i == 6));
        end
        a.en = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
